// File: rtl/cdc_channel_arbiter_pkg.sv
// Shared types and constants for the CDC channel arbiter.
// Holds the FSM state enum and the minimum-hold helper used by the elaboration check.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int MAX_REQ = 8;

  // Two slow edges must fall inside the hold window, plus margin for the synchronizer.
  function automatic int min_hold_cycles(input int t_fast, input int t_slow);
    int ratio;
    ratio = (t_slow + t_fast - 1) / t_fast;
    return 2 * ratio + 2;
  endfunction

endpackage

// File: rtl/cdc_channel_arbiter_if.sv
// Requester-side bus of the CDC channel arbiter.
// The master modport is the requester pool, the slave modport is the arbiter.
interface cdc_channel_arbiter_if #(
  parameter int N       = 12,
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  // Handshake: requester i raises req[i] with req_data word i and holds both
  // until it sees the one-cycle ack[i]; it drops req[i] before the edge that
  // ends the ack cycle. The word is sampled only at grant time, and the
  // crossing side sees xfer_data stable for the whole time xfer_active is high.
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*N-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [GW-1:0]        grant_id;
  logic [N-1:0]         xfer_data;
  logic                 xfer_active;

  modport master (
    output req, req_data,
    input  ack, grant_id, xfer_data, xfer_active
  );

  modport slave (
    input  req, req_data,
    output ack, grant_id, xfer_data, xfer_active
  );

endinterface

// File: rtl/cdc_channel_arbiter_rr_pick.sv
// Combinational rotate-and-priority-encode: first set request at or above ptr, wrapping.
// With CDC_ARB_FIXED_PRIO_EN defined the pointer is tied to zero (lowest index wins).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      winner,
  output logic               any_req
);

  logic [PW-1:0] base;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

`ifdef CDC_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign base       = '0;
`else
  assign base = ptr;
`endif

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Modular add that also works when NUM_REQ is not a power of two.
      sum = {1'b0, base} + (PW+1)'(i);
      if (sum >= (PW+1)'(NUM_REQ)) begin
        sum = sum - (PW+1)'(NUM_REQ);
      end
      idx = sum[PW-1:0];
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

endmodule

// File: rtl/cdc_channel_arbiter.sv
// Grants one fast-domain requester at a time and holds its word on the crossing input.
// Macro CDC_ARB_FIXED_PRIO_EN selects fixed priority; default is round robin.
module cdc_channel_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N           = 12,
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 14,
  parameter int T_FAST_NS   = 2000,
  parameter int T_SLOW_NS   = 11000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cdc_channel_arbiter_if.slave  bus,
  output state_t                dbg_state
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
    $error("cdc_channel_arbiter: NUM_REQ must be within 2..%0d", MAX_REQ);
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES < min_hold_cycles(T_FAST_NS, T_SLOW_NS)) begin : g_bad_hold
    $error("cdc_channel_arbiter: HOLD_CYCLES too short for the clock ratio");
  end

  state_t             state_q, state_d;
  logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [N-1:0]       xfer_data_q, xfer_data_d;
  logic               xfer_active_q, xfer_active_d;

  logic [GW-1:0]      win;
  logic               any_req;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (GW)
  ) u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .winner  (win),
    .any_req (any_req)
  );

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    ptr_d         = ptr_q;
    ack_d         = '0;
    grant_id_d    = grant_id_q;
    xfer_data_d   = xfer_data_q;
    xfer_active_d = xfer_active_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = HOLD;
          grant_id_d    = win;
          xfer_data_d   = bus.req_data[int'(win)*N +: N];
          hold_cnt_d    = CW'(HOLD_CYCLES - 1);
          xfer_active_d = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - CW'(1);
        end else begin
          state_d = ACK;
          ack_d   = NUM_REQ'(1) << grant_id_q;
        end
      end
      ACK: begin
        // The word stays on xfer_data after release; only the active flag drops.
        state_d       = IDLE;
        xfer_active_d = 1'b0;
`ifndef CDC_ARB_FIXED_PRIO_EN
        ptr_d = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      ptr_q         <= '0;
      ack_q         <= '0;
      grant_id_q    <= '0;
      xfer_data_q   <= '0;
      xfer_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      ptr_q         <= ptr_d;
      ack_q         <= ack_d;
      grant_id_q    <= grant_id_d;
      xfer_data_q   <= xfer_data_d;
      xfer_active_q <= xfer_active_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.xfer_data   = xfer_data_q;
  assign bus.xfer_active = xfer_active_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Self-checking bench for cdc_channel_arbiter: directed scenarios plus random traffic
// against a transaction-level model, and a slow-domain synchronizer for the end-to-end check.
`timescale 1ns/1ps
module tb_cdc_channel_arbiter;
  import cdc_arb_pkg::*;

  localparam int N       = 12;
  localparam int NUM_REQ = 4;
  localparam int HOLD    = 14;
  localparam int GW      = $clog2(NUM_REQ);

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic sclk    = 1'b0;
  logic reset_n = 1'b0;

  always #1000 clk  = ~clk;
  always #5500 sclk = ~sclk;

  cdc_channel_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();
  state_t dbg_state;

  cdc_channel_arbiter #(
    .N           (N),
    .NUM_REQ     (NUM_REQ),
    .HOLD_CYCLES (HOLD),
    .T_FAST_NS   (2000),
    .T_SLOW_NS   (11000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  logic [N-1:0] data_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign bus.req_data[g*N +: N] = data_arr[g];
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transfer granted at edge g: active after edges g..g+HOLD, ack after edge g+HOLD,
  // earliest next grant at edge g+HOLD+2.
  int               edge_n = 0;
  int               last_g = -1000;
  int               rr_ptr = 0;
  logic [NUM_REQ-1:0] exp_ack;
  logic [GW-1:0]    exp_gid;
  logic [N-1:0]     exp_xd;
  logic             exp_act;

  function automatic int pick(input logic [NUM_REQ-1:0] r, input int from);
    for (int k = 0; k < NUM_REQ; k++) begin
      int c;
      c = (from + k) % NUM_REQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_g  = -1000;
    rr_ptr  = 0;
    exp_ack = '0;
    exp_gid = '0;
    exp_xd  = '0;
    exp_act = 1'b0;
  endtask

  task automatic model_edge();
    int ne;
    int w;
    ne = edge_n + 1;
    if (ne >= last_g + HOLD + 2 && bus.req != '0) begin
`ifdef CDC_ARB_FIXED_PRIO_EN
      w = pick(bus.req, 0);
`else
      w = pick(bus.req, rr_ptr);
      rr_ptr = (w + 1) % NUM_REQ;
`endif
      last_g  = ne;
      exp_gid = GW'(w);
      exp_xd  = data_arr[w];
    end
    exp_act = (ne >= last_g) && (ne <= last_g + HOLD);
    exp_ack = (ne == last_g + HOLD) ? (NUM_REQ'(1) << exp_gid) : '0;
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic prev_act = 1'b0;
  int   grant_log[$];
  int   act_cnt = 0;
  int   ack_cnt = 0;

  task automatic check_outputs();
    check_val("ack",         32'(bus.ack),         32'(exp_ack));
    check_val("grant_id",    32'(bus.grant_id),    32'(exp_gid));
    check_val("xfer_data",   32'(bus.xfer_data),   32'(exp_xd));
    check_val("xfer_active", 32'(bus.xfer_active), 32'(exp_act));
    if (bus.xfer_active && !prev_act) grant_log.push_back(int'(bus.grant_id));
    prev_act = bus.xfer_active;
    if (bus.xfer_active) act_cnt++;
    if (bus.ack != '0) ack_cnt++;
  endtask

  logic [N-1:0] exp_q[$];
  logic [N-1:0] obs_q[$];
  logic [N-1:0] s1 = '0, s2 = '0, s3 = '0;
  logic         mon_en = 1'b0;

  always @(posedge sclk) begin
    s1 <= bus.xfer_data;
    s2 <= s1;
    s3 <= s2;
    if (mon_en && s2 != s3) obs_q.push_back(s2);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    if (reset_n) model_edge();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic agent(input bit always_req, input int pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ack[i]) begin
        bus.req[i] = 1'b0;
      end else if (!always_req && exp_act && int'(exp_gid) == i && bus.req[i]) begin
        // Granted requester: occasionally scribble its word or withdraw mid-hold.
        if ($urandom_range(99) < 10) data_arr[i] = N'($urandom);
        if ($urandom_range(99) < 3)  bus.req[i] = 1'b0;
      end else if (!bus.req[i] && (always_req || $urandom_range(99) < pct)) begin
        bus.req[i]  = 1'b1;
        data_arr[i] = N'($urandom);
      end
    end
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin
      agent(1'b0, 0);
      step();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    check_val("reset_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) step();
    reset_n = 1'b1;
  endtask

`ifdef CDC_ARB_FIXED_PRIO_EN
  int exp_order[5] = '{0, 0, 0, 0, 0};
`else
  int exp_order[5] = '{0, 1, 2, 3, 0};
`endif

  initial begin
    #20ms;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.req = '0;
    for (int i = 0; i < NUM_REQ; i++) data_arr[i] = N'($urandom);
    model_reset();

    // Reset held with every requester asking.
    bus.req = '1;
    repeat (4) step();
    check_val("reset_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    step();
    check_val("first_grant", 32'(bus.grant_id), 32'd0);
    check_val("first_active", 32'(bus.xfer_active), 32'd1);
    bus.req = 4'b0001;
    idle_wait(20);

    // Single request on requester 2.
    act_cnt = 0;
    ack_cnt = 0;
    data_arr[2] = 12'hB5;
    bus.req = 4'b0100;
    step();
    check_val("single_gid",  32'(bus.grant_id),  32'd2);
    check_val("single_data", 32'(bus.xfer_data), 32'h0B5);
    idle_wait(20);
    check_val("single_active_len", act_cnt, HOLD + 1);
    check_val("single_ack_pulses", ack_cnt, 1);

    // Contention from a fresh pointer.
    do_reset();
    grant_log.delete();
    repeat (70) begin
      agent(1'b1, 0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      check_val("grant_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
    end
    bus.req = '0;
    idle_wait(20);

    // Word changes mid-hold must not reach xfer_data.
    data_arr[0] = 12'hF2;
    bus.req = 4'b0001;
    step();
    repeat (5) step();
    data_arr[0] = 12'h23;
    idle_wait(20);
    check_val("stable_data", 32'(bus.xfer_data), 32'h0F2);

    // Abort mid-hold (hold_cnt == 5), then all requesters: pointer must be back at 0.
    data_arr[2] = N'($urandom);
    bus.req = 4'b0100;
    step();
    repeat (8) step();
    ack_cnt = 0;
    bus.req = '1;
    do_reset();
    check_val("abort_no_ack", ack_cnt, 0);
    step();
    check_val("abort_ptr_grant", 32'(bus.grant_id), 32'd0);
    bus.req = 4'b0001;
    idle_wait(20);

    // Random traffic.
    repeat (700) begin
      agent(1'b0, 20);
      step();
    end
    bus.req = '0;
    idle_wait(20);

    // End-to-end through a two-flop slow-domain synchronizer.
    do_reset();
    repeat (25) step();
    mon_en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      logic [N-1:0] word;
      case (w)
        0:       word = 12'hAF;
        1:       word = 12'hC4;
        default: word = 12'h4A;
      endcase
      exp_q.push_back(word);
      data_arr[1] = word;
      bus.req[1]  = 1'b1;
      step();
      idle_wait(HOLD + 2);
    end
    repeat (25) step();
    mon_en = 1'b0;
    check_val("e2e_count", obs_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      check_val("e2e_word", (k < obs_q.size()) ? 32'(obs_q[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
